// File: rtl/pdm_pkg.sv
// Shared helpers for the PDM microphone front-end.
// Holds clock divider math, result width helper and channel index enum.
package pdm_pkg;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  localparam int DEF_WINDOW = 128;

  function automatic int clk_count(
    input int clk_freq,
    input int sample_rate
  );
    longint num;
    num = longint'(clk_freq) * 64'd1000000;
    return int'(num / (2 * longint'(sample_rate)));
  endfunction

  function automatic int out_w(input int window);
    return $clog2(window);
  endfunction

  localparam int DEF_OUT_W = out_w(DEF_WINDOW);

endpackage

// File: rtl/pdm_window_acc.sv
// One boxcar accumulator: arms after OFFSET bit periods, sums WINDOW bits.
// Ports: period_end/bit_cnt (shared timing), stb/bit_in (sample), result/done.
module pdm_window_acc
  import pdm_pkg::*;
#(
  parameter int WINDOW = 128,
  parameter int OFFSET = 0,
  parameter int OUT_W  = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             period_end,
  input  logic [OUT_W-1:0] bit_cnt,
  input  logic             stb,
  input  logic             bit_in,
  output logic [OUT_W-1:0] result,
  output logic             done
);

  // Last bit index of this phase's window; also the count whose period
  // end arms a delayed phase.
  localparam logic [OUT_W-1:0] LAST =
    OUT_W'((OFFSET + WINDOW - 1) % WINDOW);

  logic             armed;
  logic [OUT_W:0]   sum;
  logic [OUT_W:0]   sum_nxt;

  assign sum_nxt = sum + {{OUT_W{1'b0}}, bit_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= (OFFSET == 0);
      sum    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!armed && period_end && bit_cnt == LAST)
        armed <= 1'b1;
      if (armed && stb) begin
        if (bit_cnt == LAST) begin
          // A full window of ones overflows OUT_W; clamp it.
          result <= sum_nxt[OUT_W] ? {OUT_W{1'b1}}
                                   : sum_nxt[OUT_W-1:0];
          sum    <= '0;
          done   <= 1'b1;
        end else begin
          sum <= sum_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/pdm_mic_frontend.sv
// PDM mic front-end: bit clock, sampling, staggered boxcar decimation.
// Ports: m_clk/m_data pins, amplitude/valid/ready out, overrun pulse;
// overrun_count exists only when PDM_OVERRUN_CNT_EN is defined.
module pdm_mic_frontend
  import pdm_pkg::*;
#(
  parameter int CLK_FREQ    = 100,
  parameter int SAMPLE_RATE = 2400000,
  parameter int WINDOW      = 128,
  parameter int PHASES      = 2,
  parameter int CHANNELS    = 1,
  localparam int OUT_W      = out_w(WINDOW)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      m_clk,
  input  logic                      m_data,
  output logic [CHANNELS*OUT_W-1:0] amplitude,
  output logic                      amplitude_valid,
  input  logic                      amplitude_ready,
`ifdef PDM_OVERRUN_CNT_EN
  output logic [7:0]                overrun_count,
`endif
  output logic                      overrun
);

  localparam int CLK_COUNT = clk_count(CLK_FREQ, SAMPLE_RATE);
  localparam int DIV_W     = $clog2(CLK_COUNT);
  localparam int NACC      = PHASES * CHANNELS;

  logic [DIV_W-1:0] div;
  logic             tc;
  logic             left_stb;
  logic             right_stb;
  logic             period_end;
  logic [OUT_W-1:0] bit_cnt;

  assign tc        = (div == DIV_W'(CLK_COUNT - 1));
  assign left_stb  = tc & m_clk;
  assign right_stb = tc & ~m_clk;
  assign period_end = (CHANNELS == 2) ? right_stb : left_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      m_clk <= 1'b0;
    end else if (tc) begin
      div   <= '0;
      m_clk <= ~m_clk;
    end else begin
      div <= div + 1'b1;
    end
  end

  // WINDOW is a power of two, so natural wrap gives modulo WINDOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_cnt <= '0;
    else if (period_end)
      bit_cnt <= bit_cnt + 1'b1;
  end

  logic [OUT_W-1:0] res [NACC];
  logic [NACC-1:0]  done;

  for (genvar p = 0; p < PHASES; p++) begin : g_ph
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic stb;
      assign stb = (c == int'(LEFT)) ? left_stb : right_stb;
      pdm_window_acc #(
        .WINDOW (WINDOW),
        .OFFSET (p * (WINDOW / PHASES)),
        .OUT_W  (OUT_W)
      ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .period_end (period_end),
        .bit_cnt    (bit_cnt),
        .stb        (stb),
        .bit_in     (m_data),
        .result     (res[p*CHANNELS+c]),
        .done       (done[p*CHANNELS+c])
      );
    end
  end

  // A phase completes when its last-sampled channel finishes; earlier
  // channels of that phase hold their result until then.
  logic                      load;
  logic [CHANNELS*OUT_W-1:0] load_data;

  always_comb begin
    load      = 1'b0;
    load_data = '0;
    for (int p = 0; p < PHASES; p++) begin
      if (done[p*CHANNELS+CHANNELS-1]) begin
        load = 1'b1;
        for (int c = 0; c < CHANNELS; c++)
          load_data[c*OUT_W +: OUT_W] = res[p*CHANNELS+c];
      end
    end
  end

  logic lost;
  assign lost = load & amplitude_valid & ~amplitude_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amplitude       <= '0;
      amplitude_valid <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      overrun <= lost;
      if (load) begin
        amplitude       <= load_data;
        amplitude_valid <= 1'b1;
      end else if (amplitude_valid && amplitude_ready) begin
        amplitude_valid <= 1'b0;
      end
    end
  end

`ifdef PDM_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_count <= '0;
    else if (lost && overrun_count != 8'hFF)
      overrun_count <= overrun_count + 1'b1;
  end
`endif

endmodule
